dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data RAM (data_mem) between the processor control unit and a host debug/loader port.
//   Sits between control/datapath and data_mem in processor.
//   Registers each request, drives the RAM for one cycle, and returns an ack with read data.
//   Arbitrates simultaneous requests round-robin (or fixed CPU priority) and keeps saturating access counters.
// PARAMETERS
//   AW            8    RAM address width
//   DW            16   RAM data width
//   CPU_PRIORITY  0    1: CPU always wins a tie; 0: round-robin
//   CNT_W         16   width of the per-requester access counters
// PORTS
//   clk         in   1     system clock, all state on rising edge
//   reset       in   1     synchronous, active-high
//   cpu_rd      in   1     CPU read request, held until cpu_ack
//   cpu_wr      in   1     CPU write request, held until cpu_ack
//   cpu_addr    in   AW    CPU address (D_addr)
//   cpu_wdata   in   DW    CPU write data (Rp)
//   cpu_rdata   out  DW    CPU read data, valid while cpu_ack=1
//   cpu_ack     out  1     one-cycle completion pulse
//   host_req    in   1     host request, held until host_ack
//   host_we     in   1     1 = write, 0 = read
//   host_addr   in   AW    host address
//   host_wdata  in   DW    host write data
//   host_rdata  out  DW    host read data, valid while host_ack=1
//   host_ack    out  1     one-cycle completion pulse
//   mem_addr    out  AW    to data_mem addra
//   mem_wdata   out  DW    to data_mem dina
//   mem_we      out  1     to data_mem wea
//   mem_rdata   in   DW    from data_mem douta (1-cycle read latency)
//   cpu_err     out  1     one-cycle pulse: cpu_rd and cpu_wr both high when sampled
//   cpu_cnt     out  CNT_W completed CPU accesses, saturating
//   host_cnt    out  CNT_W completed host accesses, saturating
// BEHAVIOUR
//   Reset: all outputs are 0, state=IDLE, last_grant=HOST (so the CPU wins the first tie).
//   FSM states: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE
//     - Sample requests (cpu_rd|cpu_wr, host_req).
//     - If any request is high, pick a winner, latch owner/addr/wdata/we into registers, go to ACCESS.
//     - If none is high, stay in IDLE.
//   ACCESS (exactly 1 cycle)
//     - mem_addr and mem_wdata come from the latched registers.
//     - mem_we = latched we.
//     - Go to RESP.
//   RESP (exactly 1 cycle)
//     - The owner's ack = 1.
//     - The owner's rdata = mem_rdata, held in an output register until the next ack to that owner.
//     - For writes, rdata is unchanged.
//     - Increment the owner's counter, saturating at all-ones.
//     - last_grant = owner. Go to IDLE.
//   Latency: request high at cycle N in IDLE -> ack at N+2. Max throughput is one access per 3 cycles.
//   Arbitration on a tie in IDLE:
//     - CPU_PRIORITY=1: the CPU wins.
//     - CPU_PRIORITY=0: the requester != last_grant wins.
//     - A lone requester always wins.
//   Requests arriving during ACCESS/RESP are not latched. They are honoured in the next IDLE if still held.
//   Requesters drop their request in the cycle after ack. A request still high in the following IDLE counts as a new access.
//   Outside ACCESS, mem_we=0 and mem_addr/mem_wdata hold their last values.
//   cpu_rd & cpu_wr together: treated as a write; cpu_err pulses for 1 cycle in the ACCESS cycle.
//   Reset mid-access: at the reset edge, state=IDLE, mem_we=0 the next cycle, no ack is issued, and counters clear.
//     The abandoned requester must re-request.
//   Changing addr/wdata after latching has no effect on the access in flight.
// TESTING
//   1. CPU write 0x00A5 @0x10, then CPU read @0x10 -> mem_we=1 one cycle; cpu_ack at N+2; cpu_rdata=0x00A5; cpu_cnt=2.
//   2. CPU read and host read both raised at the same cycle after reset, RR mode -> CPU acked first.
//      The host is acked 3 cycles later. The next tie goes to the host.
//   3. CPU_PRIORITY=1, both held continuously -> CPU acked every 3 cycles; host never acked until CPU drops its request.
//   4. cpu_rd=cpu_wr=1, addr 0x20, data 0x1234 -> cpu_err pulse; a later read of 0x20 returns 0x1234.
//   5. Host write in flight, reset asserted during ACCESS -> no host_ack; mem_we=0 after the edge; counters=0; state=IDLE.
//   6. Preload cpu_cnt near saturation (CNT_W=4) and issue 20 accesses -> cpu_cnt sticks at 0xF.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around dmem_arbiter: CPU port, host debug/loader port, data RAM port, counters.
// slave = arbiter view, master = requesters plus RAM as seen from the surrounding system.
interface dmem_arbiter_if #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic             cpu_rd;
    logic             cpu_wr;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic [DW-1:0]    cpu_rdata;
    logic             cpu_ack;
    logic             cpu_err;
    logic             host_req;
    logic             host_we;
    logic [AW-1:0]    host_addr;
    logic [DW-1:0]    host_wdata;
    logic [DW-1:0]    host_rdata;
    logic             host_ack;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_we;
    logic [DW-1:0]    mem_rdata;
    logic [CNT_W-1:0] cpu_cnt;
    logic [CNT_W-1:0] host_cnt;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_err,
        output host_rdata, host_ack,
        output mem_addr, mem_wdata, mem_we,
        output cpu_cnt, host_cnt
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_err,
        input  host_rdata, host_ack,
        input  mem_addr, mem_wdata, mem_we,
        input  cpu_cnt, host_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU and the host debug/loader port.
// state    | meaning
// S_IDLE   | sample requests, latch the winner's access
// S_ACCESS | drive the RAM for one cycle from the latched access
// S_RESP   | ack the owner, capture read data, bump its counter
module dmem_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 16,
    parameter int CPU_PRIORITY = 0,
    parameter int CNT_W        = 16
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_owner_cpu;
    logic             r_we;
    logic             r_err;
    logic             r_last_host;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_cpu_rdata;
    logic [DW-1:0]    r_host_rdata;
    logic [CNT_W-1:0] r_cpu_cnt;
    logic [CNT_W-1:0] r_host_cnt;
    logic             w_cpu_req;
    logic             w_any_req;
    logic             w_grant_cpu;

    assign w_cpu_req   = bus.cpu_rd | bus.cpu_wr;
    assign w_any_req   = w_cpu_req | bus.host_req;
    // On a tie the CPU wins under fixed priority, otherwise whoever was not served last.
    assign w_grant_cpu = w_cpu_req & (~bus.host_req | (CPU_PRIORITY != 0) | r_last_host);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_cpu  <= 1'b0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_last_host  <= 1'b1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
            r_cpu_cnt    <= '0;
            r_host_cnt   <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_req) begin
                r_owner_cpu <= w_grant_cpu;
                r_addr      <= w_grant_cpu ? bus.cpu_addr  : bus.host_addr;
                r_wdata     <= w_grant_cpu ? bus.cpu_wdata : bus.host_wdata;
                // rd+wr together is serviced as a write and flagged
                r_we        <= w_grant_cpu ? bus.cpu_wr : bus.host_we;
                r_err       <= w_grant_cpu & bus.cpu_rd & bus.cpu_wr;
            end
            if (r_state == S_RESP) begin
                r_last_host <= ~r_owner_cpu;
                if (r_owner_cpu) begin
                    if (!r_we) r_cpu_rdata <= bus.mem_rdata;
                    if (r_cpu_cnt != '1) r_cpu_cnt <= r_cpu_cnt + 1'b1;
                end else begin
                    if (!r_we) r_host_rdata <= bus.mem_rdata;
                    if (r_host_cnt != '1) r_host_cnt <= r_host_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.mem_we     = 1'b0;
        bus.cpu_err    = 1'b0;
        bus.cpu_ack    = 1'b0;
        bus.host_ack   = 1'b0;
        bus.cpu_rdata  = r_cpu_rdata;
        bus.host_rdata = r_host_rdata;
        case (r_state)
            S_ACCESS: begin
                bus.mem_we  = r_we;
                bus.cpu_err = r_err;
            end
            S_RESP: begin
                bus.cpu_ack  = r_owner_cpu;
                bus.host_ack = ~r_owner_cpu;
                if (!r_we) begin
                    if (r_owner_cpu) bus.cpu_rdata  = bus.mem_rdata;
                    else             bus.host_rdata = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_cnt   = r_cpu_cnt;
    assign bus.host_cnt  = r_host_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance (CNT_W=16) and CPU-priority instance (CNT_W=4),
// each backed by a one-cycle-latency RAM, checked against a transaction-level model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(16), .CNT_W(16)) ia ();
    dmem_arbiter_if #(.AW(8), .DW(16), .CNT_W(4))  ib ();

    dmem_arbiter #(.AW(8), .DW(16), .CPU_PRIORITY(0), .CNT_W(16)) dut_a (.clk(clk), .reset(reset_a), .bus(ia));
    dmem_arbiter #(.AW(8), .DW(16), .CPU_PRIORITY(1), .CNT_W(4))  dut_b (.clk(clk), .reset(reset_b), .bus(ib));

    logic [15:0] ram_a [256];
    logic [15:0] ram_b [256];

    always @(posedge clk) begin
        if (reset_a) begin
            for (int i = 0; i < 256; i++) ram_a[i] <= '0;
            ia.mem_rdata <= '0;
        end else begin
            if (ia.mem_we) ram_a[ia.mem_addr] <= ia.mem_wdata;
            ia.mem_rdata <= ram_a[ia.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (reset_b) begin
            for (int i = 0; i < 256; i++) ram_b[i] <= '0;
            ib.mem_rdata <= '0;
        end else begin
            if (ib.mem_we) ram_b[ib.mem_addr] <= ib.mem_wdata;
            ib.mem_rdata <= ram_b[ib.mem_addr];
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction-level reference: memory contents, who was served last, counts, held read data.
    logic [15:0] ref_mem [256];
    bit          ref_last_host;
    int          ref_cpu_cnt;
    int          ref_host_cnt;
    logic [15:0] ref_cpu_rdata;
    logic [15:0] ref_host_rdata;

    // Pending ops. cpu: 0 none, 1 read, 2 write, 3 rd+wr. host: 0 none, 1 read, 2 write.
    int          p_cpu_op;
    int          p_host_op;
    logic [7:0]  p_cpu_addr;
    logic [7:0]  p_host_addr;
    logic [15:0] p_cpu_data;
    logic [15:0] p_host_data;
    logic        first_ack_cpu;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_last_host  = 1'b1;
        ref_cpu_cnt    = 0;
        ref_host_cnt   = 0;
        ref_cpu_rdata  = '0;
        ref_host_rdata = '0;
    endtask

    task automatic drive_a();
        ia.cpu_rd     = (p_cpu_op == 1 || p_cpu_op == 3);
        ia.cpu_wr     = (p_cpu_op >= 2);
        ia.cpu_addr   = p_cpu_addr;
        ia.cpu_wdata  = p_cpu_data;
        ia.host_req   = (p_host_op != 0);
        ia.host_we    = (p_host_op == 2);
        ia.host_addr  = p_host_addr;
        ia.host_wdata = p_host_data;
    endtask

    task automatic reset_dut_a();
        p_cpu_op  = 0;
        p_host_op = 0;
        drive_a();
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        model_reset();
    endtask

    task automatic reset_dut_b();
        ib.cpu_rd = 1'b0; ib.cpu_wr = 1'b0; ib.cpu_addr = '0; ib.cpu_wdata = '0;
        ib.host_req = 1'b0; ib.host_we = 1'b0; ib.host_addr = '0; ib.host_wdata = '0;
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
    endtask

    // Presents the pending ops to dut_a at a negedge with the DUT idle and serves them all.
    task automatic serve_round_a(input string tag);
        int          cyc;
        bit          win_cpu;
        bit          first;
        bit          e_we;
        bit          e_err;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        logic        s_we;
        logic        s_err;
        logic [7:0]  s_addr;
        logic [15:0] s_wdata;
        first = 1'b1;
        drive_a();
        while (p_cpu_op != 0 || p_host_op != 0) begin
            win_cpu = (p_cpu_op != 0 && p_host_op != 0) ? ref_last_host : (p_cpu_op != 0);
            e_addr  = win_cpu ? p_cpu_addr : p_host_addr;
            e_data  = win_cpu ? p_cpu_data : p_host_data;
            e_we    = win_cpu ? (p_cpu_op >= 2) : (p_host_op == 2);
            e_err   = win_cpu && (p_cpu_op == 3);
            cyc = 0; s_we = 1'b0; s_err = 1'b0; s_addr = '0; s_wdata = '0;
            forever begin
                @(negedge clk);
                cyc++;
                if (ia.cpu_ack || ia.host_ack || cyc >= 6) break;
                s_we = ia.mem_we; s_err = ia.cpu_err; s_addr = ia.mem_addr; s_wdata = ia.mem_wdata;
            end
            if (first) first_ack_cpu = ia.cpu_ack;
            first = 1'b0;
            n_assert++;
            if (cyc !== 2) begin
                n_fail++;
                $display("FAIL %s latency: got %0d cycles, expected 2", tag, cyc);
            end
            n_assert++;
            if ({ia.cpu_ack, ia.host_ack} !== {win_cpu, ~win_cpu}) begin
                n_fail++;
                $display("FAIL %s grant: acks cpu/host=%b%b, expected %b%b", tag, ia.cpu_ack, ia.host_ack, win_cpu, ~win_cpu);
            end
            n_assert++;
            if ({s_we, s_err, s_addr} !== {e_we, e_err, e_addr}) begin
                n_fail++;
                $display("FAIL %s access: we/err/addr=%b/%b/%h, expected %b/%b/%h", tag, s_we, s_err, s_addr, e_we, e_err, e_addr);
            end
            if (e_we) begin
                n_assert++;
                if (s_wdata !== e_data) begin
                    n_fail++;
                    $display("FAIL %s wdata: got %h, expected %h", tag, s_wdata, e_data);
                end
                ref_mem[e_addr] = e_data;
            end else if (win_cpu) begin
                ref_cpu_rdata = ref_mem[e_addr];
            end else begin
                ref_host_rdata = ref_mem[e_addr];
            end
            n_assert++;
            if ({ia.cpu_rdata, ia.host_rdata} !== {ref_cpu_rdata, ref_host_rdata}) begin
                n_fail++;
                $display("FAIL %s rdata: cpu/host=%h/%h, expected %h/%h", tag, ia.cpu_rdata, ia.host_rdata, ref_cpu_rdata, ref_host_rdata);
            end
            if (win_cpu) begin
                if (ref_cpu_cnt < 65535) ref_cpu_cnt++;
                p_cpu_op = 0;
            end else begin
                if (ref_host_cnt < 65535) ref_host_cnt++;
                p_host_op = 0;
            end
            ref_last_host = ~win_cpu;
            drive_a();
            @(negedge clk);
            n_assert++;
            if ({ia.cpu_cnt, ia.host_cnt, ia.cpu_ack, ia.host_ack} !== {16'(ref_cpu_cnt), 16'(ref_host_cnt), 2'b00}) begin
                n_fail++;
                $display("FAIL %s counters: cpu/host=%0d/%0d acks=%b%b, expected %0d/%0d acks=00", tag,
                         ia.cpu_cnt, ia.host_cnt, ia.cpu_ack, ia.host_ack, ref_cpu_cnt, ref_host_cnt);
            end
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        reset_b = 1'b1;
        p_cpu_op = 0; p_host_op = 0; p_cpu_addr = '0; p_host_addr = '0; p_cpu_data = '0; p_host_data = '0;
        drive_a();
        reset_dut_b();
        reset_dut_a();
        n_assert++;
        if ({ia.cpu_ack, ia.host_ack, ia.cpu_err, ia.mem_we, ia.mem_addr, ia.mem_wdata,
             ia.cpu_rdata, ia.host_rdata, ia.cpu_cnt, ia.host_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_a outputs: ack=%b%b err=%b we=%b addr=%h wdata=%h rdata=%h/%h cnt=%0d/%0d, expected all 0",
                     ia.cpu_ack, ia.host_ack, ia.cpu_err, ia.mem_we, ia.mem_addr, ia.mem_wdata,
                     ia.cpu_rdata, ia.host_rdata, ia.cpu_cnt, ia.host_cnt);
        end
        n_assert++;
        if ({ib.cpu_ack, ib.host_ack, ib.cpu_err, ib.mem_we, ib.mem_addr, ib.mem_wdata,
             ib.cpu_rdata, ib.host_rdata, ib.cpu_cnt, ib.host_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_b outputs: ack=%b%b we=%b cnt=%0d/%0d, expected all 0",
                     ib.cpu_ack, ib.host_ack, ib.mem_we, ib.cpu_cnt, ib.host_cnt);
        end
    endtask

    task automatic test_tie_rr();
        p_cpu_op = 1;  p_cpu_addr = 8'h03;
        p_host_op = 1; p_host_addr = 8'h04;
        serve_round_a("tie_first");
        n_assert++;
        if (first_ack_cpu !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_first winner: cpu_ack=%b, expected 1", first_ack_cpu);
        end
        p_cpu_op = 2; p_cpu_addr = 8'h05; p_cpu_data = 16'h5555;
        serve_round_a("tie_cpu_only");
        p_cpu_op = 1;  p_cpu_addr = 8'h05;
        p_host_op = 1; p_host_addr = 8'h05;
        serve_round_a("tie_second");
        n_assert++;
        if (first_ack_cpu !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second winner: cpu_ack=%b, expected 0", first_ack_cpu);
        end
    endtask

    task automatic test_cpu_write_read();
        reset_dut_a();
        p_cpu_op = 2; p_cpu_addr = 8'h10; p_cpu_data = 16'h00A5;
        serve_round_a("wr_10");
        p_cpu_op = 1; p_cpu_addr = 8'h10; p_cpu_data = 16'hFFFF;
        serve_round_a("rd_10");
        n_assert++;
        if ({ia.cpu_rdata, ia.cpu_cnt} !== {16'h00A5, 16'd2}) begin
            n_fail++;
            $display("FAIL write_read: rdata=%h cnt=%0d, expected 00a5 cnt=2", ia.cpu_rdata, ia.cpu_cnt);
        end
    endtask

    task automatic test_rd_wr_err();
        p_cpu_op = 3; p_cpu_addr = 8'h20; p_cpu_data = 16'h1234;
        serve_round_a("rdwr_20");
        p_cpu_op = 1; p_cpu_addr = 8'h20; p_cpu_data = 16'h0000;
        serve_round_a("rd_20");
        n_assert++;
        if (ia.cpu_rdata !== 16'h1234) begin
            n_fail++;
            $display("FAIL rd_wr_err readback: got %h, expected 1234", ia.cpu_rdata);
        end
    endtask

    task automatic test_random_rr();
        for (int k = 0; k < 40; k++) begin
            p_cpu_op    = $urandom_range(0, 3);
            p_host_op   = $urandom_range(0, 2);
            if (p_cpu_op == 0 && p_host_op == 0) p_cpu_op = 1;
            p_cpu_addr  = 8'($urandom_range(0, 15));
            p_host_addr = 8'($urandom_range(0, 15));
            p_cpu_data  = 16'($urandom);
            p_host_data = 16'($urandom);
            serve_round_a("random");
        end
    endtask

    task automatic test_reset_mid();
        bit saw_ack;
        p_host_op = 2; p_host_addr = 8'hF0; p_host_data = 16'hBEEF;
        drive_a();
        @(negedge clk);
        n_assert++;
        if (ia.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid access: mem_we=%b, expected 1", ia.mem_we);
        end
        reset_a = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({ia.host_ack, ia.mem_we, ia.cpu_cnt, ia.host_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid after edge: ack=%b we=%b cnt=%0d/%0d, expected 0",
                     ia.host_ack, ia.mem_we, ia.cpu_cnt, ia.host_cnt);
        end
        reset_a = 1'b0;
        p_host_op = 0;
        drive_a();
        model_reset();
        saw_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ia.host_ack || ia.cpu_ack || ia.mem_we) saw_ack = 1'b1;
        end
        n_assert++;
        if (saw_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid abandoned: activity seen=%b, expected 0", saw_ack);
        end
        p_host_op = 1; p_host_addr = 8'hF0;
        serve_round_a("reset_mid_reread");
    endtask

    task automatic test_cpu_priority();
        int cpu_acks;
        int host_acks;
        int last;
        int gaps_bad;
        int cyc;
        int exp_acks;
        reset_dut_b();
        ib.cpu_rd = 1'b1; ib.cpu_addr = 8'h01;
        ib.host_req = 1'b1; ib.host_we = 1'b0; ib.host_addr = 8'h02;
        cpu_acks = 0; host_acks = 0; last = -1; gaps_bad = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (ib.host_ack) host_acks++;
            if (ib.cpu_ack) begin
                if ((last < 0 && c != 2) || (last >= 0 && c - last != 3)) gaps_bad++;
                last = c;
                cpu_acks++;
            end
        end
        exp_acks = (14 - 2) / 3 + 1;
        n_assert++;
        if (cpu_acks !== exp_acks || gaps_bad !== 0) begin
            n_fail++;
            $display("FAIL prio cpu acks: %0d acks %0d bad gaps, expected %0d acks 0 bad gaps", cpu_acks, gaps_bad, exp_acks);
        end
        n_assert++;
        if (host_acks !== 0) begin
            n_fail++;
            $display("FAIL prio host starved: %0d host acks, expected 0", host_acks);
        end
        ib.cpu_rd = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ib.host_ack && cyc < 8);
        n_assert++;
        if (cyc !== 3 || ib.cpu_cnt !== 4'(exp_acks)) begin
            n_fail++;
            $display("FAIL prio host release: host ack after %0d cycles cpu_cnt=%0d, expected 3 and %0d", cyc, ib.cpu_cnt, exp_acks);
        end
        ib.host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int ref_cnt;
        int cyc;
        reset_dut_b();
        ref_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            ib.cpu_wr = 1'b1; ib.cpu_addr = 8'(k); ib.cpu_wdata = 16'(k);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ib.cpu_ack && cyc < 8);
            ib.cpu_wr = 1'b0;
            @(negedge clk);
            if (cyc < 8) ref_cnt = (ref_cnt >= 15) ? 15 : ref_cnt + 1;
            n_assert++;
            if (cyc !== 2 || ib.cpu_cnt !== 4'(ref_cnt)) begin
                n_fail++;
                $display("FAIL saturation access %0d: latency %0d cnt %0d, expected 2 and %0d", k, cyc, ib.cpu_cnt, ref_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tie_rr();
        test_cpu_write_read();
        test_rd_wr_err();
        test_random_rr();
        test_reset_mid();
        test_cpu_priority();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
